// File: rtl/ebus_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ebus_arb : EBUS arbiter, front-end priority plus round-robin, with          |
// |            tenure timeout, registered data path and sticky fault flags.    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module ebus_arb #(
  parameter int NREQ    = 32,
  parameter int DW      = 36,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    driving,
  input  logic [NREQ*DW-1:0] data_in,
  input  logic               err_clr,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               xfer,
  output logic [DW-1:0]      ebus_data,
  output logic               timeout_err,
  output logic               conflict_err
);

  localparam int              c_pw       = $clog2(NREQ);
  localparam logic [c_pw-1:0] c_ptr_one  = c_pw'(1);
  localparam logic [c_pw-1:0] c_ptr_last = c_pw'(NREQ - 1);
  localparam logic [15:0]     c_cnt_last = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_pw-1:0] r_owner, w_owner_nxt;
  logic [c_pw-1:0] r_ptr, w_ptr_nxt;
  logic [15:0]     r_cnt, w_cnt_nxt;
  logic            r_xfer;
  logic [DW-1:0]   r_data;
  logic            r_tout, r_conf;

  logic            w_tout_set;
  logic            w_win_vld;
  logic [c_pw-1:0] w_win;
  logic [c_pw-1:0] w_idx;
  int              w_pos;
  logic            w_xfer_cond;
  logic            w_conf;
  logic [DW-1:0]   w_slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign w_slice[i] = data_in[i*DW +: DW];
  end

  // Front end wins outright; others are searched upward from r_ptr over 1..NREQ-1.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    w_pos     = 0;
    w_idx     = '0;
    if (req[0]) begin
      w_win_vld = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        w_pos = ((int'(r_ptr) - 1 + k) % (NREQ - 1)) + 1;
        w_idx = w_pos[c_pw-1:0];
        if (!w_win_vld && req[w_idx]) begin
          w_win_vld = 1'b1;
          w_win     = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_tout_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_OWN;
          w_owner_nxt = w_win;
          w_cnt_nxt   = '0;
          if (w_win != '0) begin
            w_ptr_nxt = (w_win == c_ptr_last) ? c_ptr_one : w_win + c_ptr_one;
          end
        end
      end
      ST_OWN: begin
        if (!req[r_owner]) begin
          w_state_nxt = ST_TURN;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = ST_TURN;
          w_tout_set  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_TURN: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    grant = '0;
    if (r_state == ST_OWN) begin
      grant[r_owner] = 1'b1;
    end
  end

  assign busy        = |grant;
  assign w_xfer_cond = (r_state == ST_OWN) && driving[r_owner];
  // Any driver without a grant, or more than one driver, is a bus fight.
  assign w_conf      = ($countones(driving) > 1) || (|(driving & ~grant));

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= c_ptr_one;
      r_cnt   <= '0;
      r_xfer  <= 1'b0;
      r_data  <= '0;
      r_tout  <= 1'b0;
      r_conf  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_xfer  <= w_xfer_cond;
      if (w_xfer_cond) begin
        r_data <= w_slice[r_owner];
      end
      r_tout  <= w_tout_set | (r_tout & ~err_clr);
      r_conf  <= w_conf | (r_conf & ~err_clr);
    end
  end

  assign xfer         = r_xfer;
  assign ebus_data    = r_data;
  assign timeout_err  = r_tout;
  assign conflict_err = r_conf;

endmodule
`default_nettype wire

// File: tb/tb_ebus_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ebus_arb : vector table, directed sequences and random stimulus against |
// |               a behavioural arbiter model.                                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ebus_arb;

  localparam int NREQ    = 32;
  localparam int DW      = 36;
  localparam int TIMEOUT = 16;

  logic               clk;
  logic               reset_l;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    driving;
  logic [NREQ*DW-1:0] data_in;
  logic               err_clr;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               xfer;
  logic [DW-1:0]      ebus_data;
  logic               timeout_err;
  logic               conflict_err;

  ebus_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_l(reset_l), .req(req), .driving(driving),
    .data_in(data_in), .err_clr(err_clr), .grant(grant), .busy(busy),
    .xfer(xfer), .ebus_data(ebus_data), .timeout_err(timeout_err),
    .conflict_err(conflict_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: owner index (-1 = nobody), a turnaround flag, tenure length, pointer.
  int          m_owner = -1;
  bit          m_turn  = 0;
  int          m_ten   = 0;
  int          m_ptr   = 1;
  bit          m_x     = 0;
  logic [35:0] m_d     = '0;
  bit          m_te    = 0;
  bit          m_ce    = 0;

  function automatic int pick(input logic [31:0] r, input int p);
    if (r[0]) return 0;
    for (int k = 0; k < NREQ - 1; k++) begin
      int idx;
      idx = ((p - 1 + k) % (NREQ - 1)) + 1;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_grant();
    return (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
  endfunction

  task automatic model_step(input logic rl, input logic [31:0] r, input logic [31:0] dv,
                            input logic clr, input logic [NREQ*DW-1:0] din);
    logic [31:0] g;
    bit conf, tout;
    int w;
    g = m_grant();
    if (!rl) begin
      m_owner = -1; m_turn = 0; m_ten = 0; m_ptr = 1;
      m_x = 0; m_d = '0; m_te = 0; m_ce = 0;
      return;
    end
    conf = ($countones(dv) > 1) || ((dv & ~g) != 0);
    tout = 0;
    if (m_owner >= 0 && dv[m_owner]) begin
      m_x = 1;
      m_d = din[m_owner*DW +: DW];
    end else begin
      m_x = 0;
    end
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_turn = 1;
      end else if (m_ten == TIMEOUT - 1) begin
        m_owner = -1; m_turn = 1; tout = 1;
      end else begin
        m_ten++;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_ten   = 0;
        if (w != 0) m_ptr = (w == NREQ - 1) ? 1 : w + 1;
      end
    end
    m_te = tout | (m_te & ~clr);
    m_ce = conf | (m_ce & ~clr);
  endtask

  task automatic cycle(input logic rl, input logic [31:0] r, input logic [31:0] dv,
                       input logic clr);
    reset_l = rl; req = r; driving = dv; err_clr = clr;
    model_step(rl, r, dv, clr, data_in);
    @(posedge clk);
    @(negedge clk);
    chk("grant", grant, m_grant());
    chk("busy", busy, m_owner >= 0);
    chk("xfer", xfer, m_x);
    chk("ebus_data", ebus_data, m_d);
    chk("timeout_err", timeout_err, m_te);
    chk("conflict_err", conflict_err, m_ce);
  endtask

  typedef struct {
    logic        rl;
    logic [31:0] r;
    logic [31:0] dv;
    logic        clr;
    logic [31:0] g;
    logic        x;
    logic [35:0] d;
    logic        te;
    logic        ce;
  } vec_t;

  localparam logic [35:0] OCT = 36'o123456701234;

  vec_t tbl [20];

  initial begin
    int zero_low, o, ghigh, first_run, regrant;
    logic [31:0] rq;
    int order [6];

    reset_l = 1'b0; req = '0; driving = '0; err_clr = 1'b0; data_in = '0;
    data_in[5*DW +: DW] = OCT;

    tbl[0]  = '{1'b0, 32'h0,   32'h0,     1'b0, 32'h0,   1'b0, 36'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h20,  32'h0,     1'b0, 32'h20,  1'b0, 36'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,  32'h20,    1'b0, 32'h20,  1'b1, OCT,   1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h20,  32'h0,     1'b0, 32'h20,  1'b0, OCT,   1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h0,   32'h0,     1'b0, 32'h0,   1'b0, OCT,   1'b0, 1'b0};
    tbl[5]  = '{1'b1, 32'h0,   32'h0,     1'b0, 32'h0,   1'b0, OCT,   1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h4,   32'h0,     1'b0, 32'h4,   1'b0, OCT,   1'b0, 1'b0};
    tbl[7]  = '{1'b1, 32'h4,   32'h204,   1'b0, 32'h4,   1'b1, 36'h0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 32'h0,   32'h0,     1'b0, 32'h0,   1'b0, 36'h0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 32'h0,   32'h40,    1'b0, 32'h0,   1'b0, 36'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 32'h0,   32'h0,     1'b1, 32'h0,   1'b0, 36'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 32'h0,   32'h40,    1'b0, 32'h0,   1'b0, 36'h0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 32'h0,   32'h40,    1'b1, 32'h0,   1'b0, 36'h0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 32'h0,   32'h0,     1'b1, 32'h0,   1'b0, 36'h0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 32'h20,  32'h0,     1'b0, 32'h20,  1'b0, 36'h0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 32'h20,  32'h20,    1'b0, 32'h20,  1'b1, OCT,   1'b0, 1'b0};
    tbl[16] = '{1'b0, 32'h20,  32'h0,     1'b0, 32'h0,   1'b0, 36'h0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 32'h100, 32'h0,     1'b0, 32'h100, 1'b0, 36'h0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 32'h0,   32'h0,     1'b0, 32'h0,   1'b0, 36'h0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 32'h0,   32'h0,     1'b0, 32'h0,   1'b0, 36'h0, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].rl, tbl[i].r, tbl[i].dv, tbl[i].clr);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_busy", i), busy, |tbl[i].g);
      chk($sformatf("tbl%0d_xfer", i), xfer, tbl[i].x);
      chk($sformatf("tbl%0d_data", i), ebus_data, tbl[i].d);
      chk($sformatf("tbl%0d_tout", i), timeout_err, tbl[i].te);
      chk($sformatf("tbl%0d_conf", i), conflict_err, tbl[i].ce);
    end

    // Requesters 0, 3, 7: front end rests for two foreign grants after each tenure.
    order = '{0, 3, 7, 0, 3, 7};
    zero_low = 0;
    rq = 32'h89;
    for (int gi = 0; gi < 6; gi++) begin
      cycle(1'b1, rq, 32'h0, 1'b0);
      chk($sformatf("rr_grant%0d", gi), grant, 32'd1 << order[gi]);
      o = order[gi];
      if (o == 0) zero_low = 2;
      else if (zero_low > 0) zero_low--;
      cycle(1'b1, rq & ~(32'd1 << o), 32'h0, 1'b0);
      chk($sformatf("rr_dead1_%0d", gi), grant, 32'h0);
      rq = 32'h88 | ((zero_low == 0) ? 32'h1 : 32'h0);
      cycle(1'b1, rq, 32'h0, 1'b0);
      chk($sformatf("rr_dead2_%0d", gi), grant, 32'h0);
    end
    cycle(1'b1, 32'h0, 32'h0, 1'b0);

    // Pointer wrap from 31 to 2, then pointer left at 3.
    cycle(1'b1, 32'h4000_0000, 32'h0, 1'b0);
    chk("wrap_g30", grant, 32'h4000_0000);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h8000_0004, 32'h0, 1'b0);
    chk("wrap_g31", grant, 32'h8000_0000);
    cycle(1'b1, 32'h4, 32'h0, 1'b0);
    cycle(1'b1, 32'h4, 32'h0, 1'b0);
    cycle(1'b1, 32'h4, 32'h0, 1'b0);
    chk("wrap_g2", grant, 32'h4);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'ha, 32'h0, 1'b0);
    chk("wrap_ptr3", grant, 32'h8);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);

    // Timeout: requester 4 holds req for 40 cycles.
    ghigh = 0; first_run = -1; regrant = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, 32'h10, 32'h0, 1'b0);
      if (grant[4]) begin
        ghigh++;
        if (first_run >= 0) regrant = 1;
      end else if (ghigh > 0 && first_run < 0) begin
        first_run = ghigh;
      end
    end
    chk("tout_run_len", first_run, 16);
    chk("tout_regrant", regrant, 1);
    chk("tout_flag", timeout_err, 1'b1);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 32'h0, 1'b1);
    chk("tout_clear", timeout_err, 1'b0);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);

    // Random traffic against the model.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] dv;
      logic rl, clr;
      for (int j = 0; j < NREQ * DW / 32; j++) data_in[j*32 +: 32] = $urandom;
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, (b == 0) ? 59 : 19) == 0) rq[b] = ~rq[b];
      end
      dv = '0;
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) dv[m_owner] = 1'b1;
      if ($urandom_range(0, 29) == 0) dv[$urandom_range(0, NREQ - 1)] = 1'b1;
      rl  = ($urandom_range(0, 199) != 0);
      clr = ($urandom_range(0, 9) == 0);
      cycle(rl, rq, dv, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ebus_arb.md
EBUS_ARB -- requirements
Module: ebus_arb

Interface
- REQ-001 SHALL: parameter NREQ, default 32, the number of EBUS requesters; index 0 is the front end.
- REQ-002 SHALL: parameter DW, default 36, the EBUS data width.
- REQ-003 SHALL: parameter TIMEOUT, default 255, the maximum cycles one owner may hold the bus (range 2..65535).
- REQ-004 SHALL: clk  in  1  the single system clock; all logic on its rising edge.
- REQ-005 SHALL: reset_l  in  1  reset, synchronous and active-low.
- REQ-006 SHALL: req  in  NREQ  request vector; bit i high while requester i wants the bus.
- REQ-007 SHALL: driving  in  NREQ  per-requester data-valid flag.
- REQ-008 SHALL: data_in  in  NREQ*DW  requester data; slice i occupies bits [i*DW +: DW].
- REQ-009 SHALL: err_clr  in  1  clears the sticky error flags.
- REQ-010 SHALL: grant  out  NREQ  ownership vector, one-hot or zero.
- REQ-011 SHALL: busy  out  1  high while grant is non-zero.
- REQ-012 SHALL: xfer  out  1  EBUS transfer strobe.
- REQ-013 SHALL: ebus_data  out  DW  registered EBUS data.
- REQ-014 SHALL: timeout_err  out  1  sticky flag; an owner was forced off the bus.
- REQ-015 SHALL: conflict_err  out  1  sticky flag; illegal or multiple drivers were seen.

Function
- REQ-016 SHALL: FSM states are IDLE, OWN and TURN; grant is non-zero only in OWN.
- REQ-017 SHALL: in IDLE with req non-zero, the winner W is registered and the FSM goes to OWN; grant[W] asserts the cycle after the request is sampled.
- REQ-018 SHALL: arbitration gives req[0] absolute priority; otherwise it is round-robin over 1..NREQ-1, searching upward from ptr with wrap-around from NREQ-1 to 1.
- REQ-019 SHALL: on entry to OWN with W!=0, ptr becomes W+1, wrapping from NREQ to 1; a front-end grant leaves ptr unchanged.
- REQ-020 SHALL: in IDLE with req zero, the FSM stays in IDLE with grant=0.
- REQ-021 SHALL: in OWN, a tenure counter starts at 0 and increments every cycle.
- REQ-022 SHALL: in OWN, if req[W] is sampled low, the next state is TURN.
- REQ-023 SHALL: in OWN, if the counter equals TIMEOUT-1 while req[W] is still high, the next state is TURN and timeout_err is set.
- REQ-024 SHALL: TURN lasts exactly one cycle with grant=0, then goes to IDLE.
- REQ-025 SHALL: the minimum gap between successive grants is 2 dead cycles (TURN, IDLE).
- REQ-026 SHALL: xfer is registered; xfer=1 in the cycle after a cycle that was in OWN with driving[W]=1, else 0.
- REQ-027 SHALL: ebus_data loads data_in slice W whenever that xfer condition is true; otherwise it holds its last value.
- REQ-028 SHALL: conflict_err is set in any cycle where popcount(driving)>1, or driving[i]=1 with grant[i]=0 (including TURN/IDLE).
- REQ-029 SHALL: err_clr clears both sticky flags next cycle; set wins over a simultaneous clear.
- REQ-030 SHALL: a requester that drops and re-raises req during TURN is re-arbitrated in IDLE like any other requester.
- REQ-031 SHALL: a req bit that rises while another requester owns the bus has no effect until the next IDLE.

Reset
- REQ-032 SHALL: while reset_l=0 at a clock edge, the block resets: state=IDLE, grant=0, busy=0, xfer=0, ebus_data=0, counter=0, ptr=1, timeout_err=0, conflict_err=0.
- REQ-033 SHALL: reset asserted mid-tenure drops grant at the next edge, with no TURN cycle.
- REQ-034 SHALL: the first arbitration after reset release occurs in the first cycle with reset_l=1.

Verification (NREQ=32, DW=36, TIMEOUT=16)
- REQ-035 SHALL: req=bit5 at cycle 0 -> grant=0x20 and busy=1 at cycle 1; driving[5] with data 0o123456701234 -> xfer=1 and ebus_data=0o123456701234 one cycle later; req drop -> grant=0 next cycle.
- REQ-036 SHALL: req bits 0, 3 and 7 held together -> grant order is 0, 3, 7, 0, 3, ..., with each tenure ended by dropping req, and 2 dead cycles between grants.
- REQ-037 SHALL: ptr=31 and req bits 31 and 2 -> 31 is granted, then 2 (wrap), ptr=3 afterwards.
- REQ-038 SHALL: req[4] held 40 cycles -> grant[4] high exactly 16 cycles, timeout_err=1, then 4 is re-granted after TURN/IDLE; err_clr -> timeout_err=0.
- REQ-039 SHALL: driving=bits 2 and 9 while grant[2] is held -> conflict_err=1; driving[6] in IDLE -> conflict_err=1; err_clr with no fault -> conflict_err=0.
- REQ-040 SHALL: reset_l=0 during a bit-5 tenure -> all outputs zero next edge; after release, req bit 8 -> grant=0x100 one cycle later.
